cache: RTL and testbench
========================

// Module: cache
// PURPOSE
//  Direct-mapped, write-back data cache between the CPU memory port (32-bit, byte-enabled,
//  word-aligned) and a 64-bit burst RAM controller (PSRAM style, 4-beat bursts).
//  Sits inside the RAM/IO block; the UART/LED decode above it gates enable for I/O addresses.
// PARAMETERS
//  LINE_IX_BITWIDTH    1   log2(number of cache lines); line = 32 bytes = 8 words = 4 beats
//  RAM_DEPTH_BITWIDTH  10  width of br_addr; RAM size = 2^RAM_DEPTH_BITWIDTH 64-bit words
//  RAM_ADDRESSING_MODE 3   br_addr = byte address >> 3 (64-bit word addressing); only 3 supported
// PORTS
//  clk              in   1   clock; all state on rising edge
//  rst_n            in   1   reset, asynchronous, active low
//  enable           in   1   request valid; 0 = idle, no state change, busy=0
//  address          in   32  byte address, bits[1:0] ignored (word aligned)
//  data_in          in   32  write data, lane-aligned (byte n in bits 8n+7:8n)
//  write_enable     in   4   byte write strobes; 0000 = read
//  data_out         out  32  word at address (combinational from line storage)
//  data_out_ready   out  1   read hit: data_out valid this cycle
//  busy             out  1   miss/refill in progress; caller holds request stable
//  br_cmd           out  1   0 read, 1 write
//  br_cmd_en        out  1   one-cycle command strobe
//  br_addr          out  RAM_DEPTH_BITWIDTH  64-bit-word burst start address (line aligned)
//  br_wr_data       out  64  write-burst beat
//  br_data_mask     out  8   tied 0 (write all bytes)
//  br_rd_data       in   64  read-burst beat
//  br_rd_data_valid in   1   br_rd_data valid; 4 consecutive cycles per read burst
// BEHAVIOUR
//  Address split: offset=address[4:2] (word), beat=address[4:3], index=address[5+:LINE_IX],
//   tag=address[RAM_DEPTH_BITWIDTH+2:5+LINE_IX]; higher bits ignored (alias).
//  Per line: valid, dirty, tag, 8x32 data. hit = enable & valid[ix] & tag match.
//  Reset: all valid/dirty=0, state IDLE, br_cmd=0, br_cmd_en=0, br_addr=0, br_wr_data=0.
//  Comb: busy = enable & (!hit | state!=IDLE); data_out_ready = enable & hit & write_enable==0
//   & state==IDLE; data_out = line[ix].word[offset] (don't-care on miss; drive 0).
//  Write hit (IDLE): strobed bytes written at clock edge, dirty<=1, busy=0, zero wait.
//  States: IDLE -> (miss & dirty) WB -> RD_CMD -> RD_WAIT -> IDLE; (miss & clean) RD_CMD.
//   WB: cycle 0 br_cmd_en=1, br_cmd=1, br_addr={old tag,index,00}, br_wr_data=beat0;
//    beats 1..3 on next 3 cycles (br_cmd_en=0); then RD_CMD.
//   RD_CMD: br_cmd_en=1 one cycle, br_cmd=0, br_addr={tag,index,00} of request -> RD_WAIT.
//   RD_WAIT: each br_rd_data_valid stores beat k (k=0..3, low word = even word); after beat 3:
//    valid<=1, dirty<=0, tag updated -> IDLE. Request re-evaluates next cycle and hits;
//    a pending write is then applied as a write hit.
//  Beat word order: beat k bits[31:0]=word 2k, bits[63:32]=word 2k+1.
//  enable dropped mid-refill: refill completes regardless; state is not aborted.
//  br_rd_data_valid outside RD_WAIT ignored. Reset mid-burst: state lost, lines invalidated.
//  Expected size 150-300 lines RTL; line storage in registers or BRAM (comb read required).
// TESTING
//  1 After reset, read 0x00000000 -> busy=1, one read cmd br_addr=0, 4 beats of
//    0x1111111100000000,..; then data_out_ready=1, data_out=0x00000000; read 0x4 -> 0x11111111 hit.
//  2 Write 0x0000_0008 data 0xDEADBEEF we=1111 on resident line -> no busy; read back 0xDEADBEEF.
//  3 Byte write we=0100 data 0x00AB0000 to 0x8 -> word reads 0xDEABBEEF.
//  4 Access conflicting tag (LINE_IX=1: 0x40) after dirty line -> write burst br_cmd=1 br_addr=0
//    with modified beat 1 = 0x00000000DEABBEEF, then read burst br_addr=8; dirty=0 afterwards.
//  5 Clean-line conflict -> no write burst, only read cmd; br_data_mask always 0.
//  6 Assert rst_n=0 during RD_WAIT -> outputs return to reset values, next access misses.

Source files
------------

// File: rtl/cache_if.sv
// Bus bundle between the CPU memory port, the cache and the 64-bit burst RAM
// controller. The slave modport is the cache side. The master modport is the
// environment side: the CPU requester plus the RAM controller.
//   CPU : enable, address, data_in, write_enable -> data_out, data_out_ready, busy
//   RAM : br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask <- br_rd_data, br_rd_data_valid
interface cache_if #(
  parameter int RAM_DEPTH_BITWIDTH = 10
);
  logic                          enable;
  logic [31:0]                   address;
  logic [31:0]                   data_in;
  logic [3:0]                    write_enable;
  logic [31:0]                   data_out;
  logic                          data_out_ready;
  logic                          busy;
  logic                          br_cmd;
  logic                          br_cmd_en;
  logic [RAM_DEPTH_BITWIDTH-1:0] br_addr;
  logic [63:0]                   br_wr_data;
  logic [7:0]                    br_data_mask;
  logic [63:0]                   br_rd_data;
  logic                          br_rd_data_valid;

  modport slave (
    input  enable, address, data_in, write_enable, br_rd_data, br_rd_data_valid,
    output data_out, data_out_ready, busy, br_cmd, br_cmd_en, br_addr, br_wr_data,
           br_data_mask
  );

  modport master (
    output enable, address, data_in, write_enable, br_rd_data, br_rd_data_valid,
    input  data_out, data_out_ready, busy, br_cmd, br_cmd_en, br_addr, br_wr_data,
           br_data_mask
  );
endinterface

// File: rtl/cache.sv
// Direct-mapped write-back data cache. It sits between a 32-bit byte-enabled CPU
// port and a 64-bit, 4-beat burst RAM controller. A line holds 32 bytes, which is
// 8 words or 4 beats.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cache_if.slave. It carries the CPU request/response and the
//                burst RAM command/data signals.
// Read hits and write hits complete with zero wait. A miss writes back the victim
// line if it is dirty, then refills the line. After the refill the held request
// hits.
module cache #(
  parameter int LINE_IX_BITWIDTH    = 1,
  parameter int RAM_DEPTH_BITWIDTH  = 10,
  parameter int RAM_ADDRESSING_MODE = 3
) (
  input  logic    clk,
  input  logic    rst_n,
  cache_if.slave  bus
);
  localparam int NLINES = 1 << LINE_IX_BITWIDTH;
  localparam int TAG_LO = 5 + LINE_IX_BITWIDTH;
  localparam int TAG_HI = RAM_DEPTH_BITWIDTH + 2;
  localparam int TAG_W  = TAG_HI - TAG_LO + 1;
  localparam logic AM_OK = (RAM_ADDRESSING_MODE == 3);

  typedef enum logic [1:0] {S_IDLE, S_WB, S_RD_CMD, S_RD_WAIT} state_t;

  state_t                        r_state;
  logic [1:0]                    r_cnt;      // beat index for write-back / refill
  logic [NLINES-1:0]             r_valid;
  logic [NLINES-1:0]             r_dirty;
  logic [TAG_W-1:0]              r_tag [NLINES];
  logic [7:0][31:0]              r_data [NLINES];
  logic [LINE_IX_BITWIDTH-1:0]   r_ix_req;   // line being refilled
  logic [TAG_W-1:0]              r_tag_req;  // tag being fetched
  logic                          r_br_cmd;
  logic                          r_br_cmd_en;
  logic [RAM_DEPTH_BITWIDTH-1:0] r_br_addr;
  logic [63:0]                   r_br_wr_data;

  logic [2:0]                    w_off;
  logic [LINE_IX_BITWIDTH-1:0]   w_ix;
  logic [TAG_W-1:0]              w_tag;
  logic                          w_hit, w_idle, w_rd, w_wr_hit, w_miss, w_fill;
  logic                          w_unused;

  assign w_off  = bus.address[4:2];
  assign w_ix   = bus.address[5 +: LINE_IX_BITWIDTH];
  assign w_tag  = bus.address[TAG_HI:TAG_LO];
  assign w_hit  = bus.enable & r_valid[w_ix] & (r_tag[w_ix] == w_tag);
  assign w_idle = (r_state == S_IDLE);
  assign w_rd   = (bus.write_enable == 4'b0000);
  assign w_wr_hit = w_hit & ~w_rd & w_idle;
  assign w_miss   = bus.enable & ~w_hit & w_idle;
  assign w_fill   = (r_state == S_RD_WAIT) & bus.br_rd_data_valid;

  // The high address bits alias. The byte offset is ignored for word accesses.
  assign w_unused = &{1'b0, bus.address[31:TAG_HI+1], bus.address[1:0], AM_OK};

  assign bus.busy           = bus.enable & (~w_hit | ~w_idle);
  assign bus.data_out_ready = w_hit & w_rd & w_idle;
  assign bus.data_out       = w_hit ? r_data[w_ix][w_off] : 32'h0;
  assign bus.br_data_mask   = 8'h00;
  assign bus.br_cmd         = r_br_cmd;
  assign bus.br_cmd_en      = r_br_cmd_en;
  assign bus.br_addr        = r_br_addr;
  assign bus.br_wr_data     = r_br_wr_data;

  // Control FSM with registered burst-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 2'd0;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_ix_req     <= '0;
      r_tag_req    <= '0;
      r_br_cmd     <= 1'b0;
      r_br_cmd_en  <= 1'b0;
      r_br_addr    <= '0;
      r_br_wr_data <= '0;
      for (int i = 0; i < NLINES; i++) r_tag[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr_hit) begin
            r_dirty[w_ix] <= 1'b1;
          end else if (w_miss) begin
            r_ix_req    <= w_ix;
            r_tag_req   <= w_tag;
            r_br_cmd_en <= 1'b1;
            if (r_valid[w_ix] & r_dirty[w_ix]) begin
              // Beat 0 goes out with the command. Beats 1..3 follow.
              r_state      <= S_WB;
              r_br_cmd     <= 1'b1;
              r_br_addr    <= {r_tag[w_ix], w_ix, 2'b00};
              r_br_wr_data <= r_data[w_ix][1:0];
              r_cnt        <= 2'd1;
            end else begin
              r_state   <= S_RD_CMD;
              r_br_cmd  <= 1'b0;
              r_br_addr <= {w_tag, w_ix, 2'b00};
            end
          end
        end
        S_WB: begin
          r_br_cmd_en <= 1'b0;
          if (r_cnt != 2'd0) begin
            r_br_wr_data <= r_data[r_ix_req][{r_cnt, 1'b1} -: 2];
            r_cnt        <= r_cnt + 2'd1;
          end else begin
            // r_cnt wrapped to 0, so beat 3 is on the bus this cycle.
            r_state     <= S_RD_CMD;
            r_br_cmd_en <= 1'b1;
            r_br_cmd    <= 1'b0;
            r_br_addr   <= {r_tag_req, r_ix_req, 2'b00};
          end
        end
        S_RD_CMD: begin
          r_br_cmd_en <= 1'b0;
          r_cnt       <= 2'd0;
          r_state     <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (bus.br_rd_data_valid) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_valid[r_ix_req] <= 1'b1;
              r_dirty[r_ix_req] <= 1'b0;
              r_tag[r_ix_req]   <= r_tag_req;
              r_state           <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line storage has no reset. Valid bits guard its contents.
  always_ff @(posedge clk) begin
    if (w_wr_hit) begin
      for (int b = 0; b < 4; b++)
        if (bus.write_enable[b]) r_data[w_ix][w_off][8*b +: 8] <= bus.data_in[8*b +: 8];
    end
    if (w_fill) r_data[r_ix_req][{r_cnt, 1'b1} -: 2] <= bus.br_rd_data;
  end
endmodule

// File: tb/tb_cache.sv
module tb_cache;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_if #(.RAM_DEPTH_BITWIDTH(10)) bus ();

  cache #(.LINE_IX_BITWIDTH(1), .RAM_DEPTH_BITWIDTH(10), .RAM_ADDRESSING_MODE(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: backing RAM, the CPU-visible word memory, and which line is resident.
  logic [63:0] mem  [1024];
  logic [31:0] gold [2048];
  logic        mv [2];
  logic        md [2];
  logic [6:0]  mtag [2];
  logic [10:0] cmdq [$];   // {br_cmd, br_addr} as seen by the RAM

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin mv[i] = 1'b0; md[i] = 1'b0; mtag[i] = '0; end
    for (int w = 0; w < 2048; w++)
      gold[w] = w[0] ? mem[w >> 1][63:32] : mem[w >> 1][31:0];
  endtask

  // Burst RAM controller responder.
  initial begin
    logic [9:0]  a;
    logic [63:0] wb [4];
    bus.br_rd_data_valid = 1'b0;
    bus.br_rd_data       = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.br_cmd_en) begin
        a = bus.br_addr;
        cmdq.push_back({bus.br_cmd, a});
        if (bus.br_cmd) begin
          wb[0] = bus.br_wr_data;
          for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("wb_cmd_en_low", bus.br_cmd_en, 0);
            wb[k] = bus.br_wr_data;
          end
          for (int k = 0; k < 4; k++) mem[a + k[9:0]] = wb[k];
        end else begin
          repeat ($urandom_range(1, 3)) @(negedge clk);
          for (int k = 0; k < 4; k++) begin
            if (!rst_n) break;
            bus.br_rd_data_valid = 1'b1;
            bus.br_rd_data       = mem[a + k[9:0]];
            @(negedge clk);
          end
          bus.br_rd_data_valid = 1'b0;
        end
      end
    end
  end

  // Per-cycle output checks against the model.
  always @(negedge clk) begin
    chk("data_mask", bus.br_data_mask, 0);
    if (rst_n && bus.enable && bus.data_out_ready)
      chk("hit_data", bus.data_out, gold[bus.address[12:2]]);
    if (rst_n && !bus.enable) begin
      chk("idle_busy", bus.busy, 0);
      chk("idle_ready", bus.data_out_ready, 0);
    end
  end

  // One CPU access. The task is entered just after a rising edge and returns just
  // after the rising edge that completes the access.
  task automatic access(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] we, output logic [31:0] rd);
    int ix, w, cyc;
    logic [6:0] tg;
    logic ph;
    logic [9:0] wba, rda;
    logic [10:0] base;
    ix = int'(a[5]); tg = a[12:6]; w = int'(a[12:2]);
    ph = mv[ix] && (mtag[ix] == tg);
    cmdq.delete();
    bus.enable = 1'b1; bus.address = a; bus.data_in = d; bus.write_enable = we;
    @(negedge clk);
    chk("busy_first", bus.busy, !ph);
    cyc = 0;
    while (bus.busy && cyc < 100) begin @(negedge clk); cyc++; end
    chk("refill_in_budget", cyc < 100, 1);
    rd = bus.data_out;
    if (we == 4'b0) begin
      chk("read_ready", bus.data_out_ready, 1);
      chk("read_data", rd, gold[w]);
    end else chk("write_no_ready", bus.data_out_ready, 0);
    if (!ph) begin
      rda = {tg, a[5], 2'b00};
      if (mv[ix] && md[ix]) begin
        wba  = {mtag[ix], a[5], 2'b00};
        base = {mtag[ix], a[5], 3'b000};
        chk("cmd_count", cmdq.size(), 2);
        if (cmdq.size() == 2) begin
          chk("wb_cmd", cmdq[0], {1'b1, wba});
          chk("rd_cmd", cmdq[1], {1'b0, rda});
        end
        for (int k = 0; k < 4; k++)
          chk("wb_beat", mem[wba + k[9:0]], {gold[base + 11'(2*k+1)], gold[base + 11'(2*k)]});
      end else begin
        chk("cmd_count", cmdq.size(), 1);
        if (cmdq.size() == 1) chk("rd_cmd", cmdq[0], {1'b0, rda});
      end
      mv[ix] = 1'b1; mtag[ix] = tg; md[ix] = 1'b0;
    end else chk("hit_no_cmd", cmdq.size(), 0);
    @(posedge clk); #1;
    if (we != 4'b0) begin
      for (int b = 0; b < 4; b++) if (we[b]) gold[w][8*b +: 8] = d[8*b +: 8];
      md[ix] = 1'b1;
    end
    bus.enable = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, a;
    int cyc;
    bus.enable = 1'b0; bus.address = '0; bus.data_in = '0; bus.write_enable = '0;
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
    mem[0] = 64'h11111111_00000000;
    mem[1] = 64'h0;
    model_reset();

    #22;
    chk("rst_cmd_en", bus.br_cmd_en, 0);
    chk("rst_cmd", bus.br_cmd, 0);
    chk("rst_addr", bus.br_addr, 0);
    chk("rst_wr_data", bus.br_wr_data, 0);
    chk("rst_busy", bus.busy, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Cold miss, then a hit in the same line.
    access(32'h0, 32'h0, 4'b0000, rd);
    chk("t1_word0", rd, 32'h0);
    chk("t1_rd_addr", cmdq[0], 11'h000);
    access(32'h4, 32'h0, 4'b0000, rd);
    chk("t1_word1", rd, 32'h11111111);
    // Full-word and byte write hits.
    access(32'h8, 32'hDEADBEEF, 4'b1111, rd);
    access(32'h8, 32'h0, 4'b0000, rd);
    chk("t2_word", rd, 32'hDEADBEEF);
    access(32'h8, 32'h00AB0000, 4'b0100, rd);
    access(32'h8, 32'h0, 4'b0000, rd);
    chk("t3_word", rd, 32'hDEABBEEF);
    // Dirty conflict: the victim line is written back, then the new line is fetched.
    access(32'h40, 32'h0, 4'b0000, rd);
    chk("t4_wb_addr", cmdq[0], {1'b1, 10'd0});
    chk("t4_rd_addr", cmdq[1], {1'b0, 10'd8});
    chk("t4_beat1", mem[1], 64'h00000000_DEABBEEF);
    // Clean conflict: only a read burst is issued.
    access(32'h0, 32'h0, 4'b0000, rd);
    chk("t5_only_read", cmdq.size(), 1);

    // Reset asserted during the refill.
    bus.enable = 1'b1; bus.address = 32'h20; bus.write_enable = 4'b0;
    cyc = 0;
    do begin @(negedge clk); #2; cyc++; end while (!bus.br_rd_data_valid && cyc < 50);
    chk("t6_saw_beat", bus.br_rd_data_valid, 1);
    rst_n = 1'b0; bus.enable = 1'b0; #1;
    chk("t6_cmd_en", bus.br_cmd_en, 0);
    chk("t6_cmd", bus.br_cmd, 0);
    chk("t6_addr", bus.br_addr, 0);
    chk("t6_wr_data", bus.br_wr_data, 0);
    chk("t6_busy", bus.busy, 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    access(32'h0, 32'h0, 4'b0000, rd);   // busy_first inside the task expects a miss

    // enable dropped mid-refill: the refill still completes and the line becomes resident.
    bus.enable = 1'b1; bus.address = 32'h24; bus.write_enable = 4'b0;
    @(negedge clk);
    chk("drop_busy", bus.busy, 1);
    @(posedge clk); #1; bus.enable = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    mv[1] = 1'b1; mtag[1] = 7'd0; md[1] = 1'b0;
    access(32'h24, 32'h0, 4'b0000, rd);

    // Random traffic over a few conflicting tags, with random aliasing high bits.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] we;
      a = ($urandom & 32'hFFFFE000) | (32'($urandom_range(0, 3)) << 6) |
          (32'($urandom_range(0, 1)) << 5) | (32'($urandom_range(0, 7)) << 2) |
          32'($urandom_range(0, 3));
      we = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      access(a, $urandom, we, rd);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
